// File: rtl/thermo_encoder.sv
// thermo_encoder: binary position code -> thermometer word.
// Two-stage valid/ready pipeline (code select, then thermometer expand)
// with a built-in sweep FSM that ramps codes 0..sweep_max for self-test
// and calibration of the TDC decoder chain.
module thermo_encoder #(
  parameter int WIDTH  = 40,
  parameter int CODE_W = 6,
  parameter int HOLD_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] in_code,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              sweep_start,
  input  logic [CODE_W-1:0] sweep_max,
  input  logic [HOLD_W-1:0] sweep_hold,
  output logic [WIDTH-1:0]  out_therm,
  output logic [CODE_W-1:0] out_code,
  output logic              out_sat,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              sweep_busy,
  output logic              sweep_done
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HOLD, S_DRAIN} state_t;

  // Bit i is set when the code lies above position i; codes at or above
  // WIDTH naturally give all ones.
  function automatic logic [WIDTH-1:0] therm_of(input logic [CODE_W-1:0] n);
    logic [WIDTH-1:0] t;
    t = '0;
    for (int i = 0; i < WIDTH; i++) begin
      t[i] = (int'(n) > i);
    end
    return t;
  endfunction

  // Saturation flag only for codes strictly beyond the word width.
  function automatic logic sat_of(input logic [CODE_W-1:0] n);
    return (int'(n) > WIDTH);
  endfunction

  state_t              state_q, state_d;
  logic [CODE_W-1:0]   cnt_q, cnt_d;
  logic [CODE_W-1:0]   max_q, max_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [HOLD_W-1:0]   hcnt_q, hcnt_d;
  logic                done_q, done_d;

  logic                s1_vld_q, s1_vld_d;
  logic [CODE_W-1:0]   s1_code_q, s1_code_d;
  logic                s1_last_q, s1_last_d;

  logic                s2_vld_q, s2_vld_d;
  logic [WIDTH-1:0]    s2_therm_q, s2_therm_d;
  logic [CODE_W-1:0]   s2_code_q, s2_code_d;
  logic                s2_sat_q, s2_sat_d;
  logic                s2_last_q, s2_last_d;

  logic                s2_adv;
  logic                s1_ready;
  logic                sw_vld;
  logic                s1_load;
  logic [CODE_W-1:0]   sel_code;
  logic                sel_last;

  // A stage can take new data when it is empty or its content moves on.
  assign s2_adv   = !s2_vld_q || out_ready;
  assign s1_ready = !s1_vld_q || s2_adv;
  assign sw_vld   = (state_q == S_RUN);
  // External input is refused when a sweep is running or about to start.
  assign in_ready = (state_q == S_IDLE) && !sweep_start && s1_ready;
  assign s1_load  = sw_vld ? s1_ready : (in_valid && in_ready);
  assign sel_code = sw_vld ? cnt_q : in_code;
  assign sel_last = sw_vld && (cnt_q == max_q);

  assign out_therm  = s2_therm_q;
  assign out_code   = s2_code_q;
  assign out_sat    = s2_sat_q;
  assign out_valid  = s2_vld_q;
  assign sweep_busy = (state_q != S_IDLE);
  assign sweep_done = done_q;

  // Pipeline next-state: stage 1 selects the code, stage 2 expands it.
  always_comb begin
    s1_vld_d   = s1_vld_q;
    s1_code_d  = s1_code_q;
    s1_last_d  = s1_last_q;
    s2_vld_d   = s2_vld_q;
    s2_therm_d = s2_therm_q;
    s2_code_d  = s2_code_q;
    s2_sat_d   = s2_sat_q;
    s2_last_d  = s2_last_q;
    if (s1_load) begin
      s1_vld_d  = 1'b1;
      s1_code_d = sel_code;
      s1_last_d = sel_last;
    end else if (s2_adv) begin
      s1_vld_d  = 1'b0;
    end
    if (s2_adv) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        s2_therm_d = therm_of(s1_code_q);
        s2_code_d  = s1_code_q;
        s2_sat_d   = sat_of(s1_code_q);
        s2_last_d  = s1_last_q;
      end
    end
  end

  // Sweep FSM next-state: ramp, hold each code, then drain the last word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    max_d   = max_q;
    hold_d  = hold_q;
    hcnt_d  = hcnt_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sweep_start) begin
          max_d   = sweep_max;
          hold_d  = sweep_hold;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (s1_ready) begin
          if (cnt_q == max_q) begin
            state_d = S_DRAIN;
          end else if (hold_q <= HOLD_W'(1)) begin
            cnt_d = cnt_q + CODE_W'(1);
          end else begin
            hcnt_d  = hold_q - HOLD_W'(1);
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (hcnt_q <= HOLD_W'(1)) begin
          hcnt_d  = '0;
          cnt_d   = cnt_q + CODE_W'(1);
          state_d = S_RUN;
        end else begin
          hcnt_d = hcnt_q - HOLD_W'(1);
        end
      end
      S_DRAIN: begin
        if (s2_vld_q && out_ready && s2_last_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and pipeline registers; reset discards everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      max_q      <= '0;
      hold_q     <= '0;
      hcnt_q     <= '0;
      done_q     <= 1'b0;
      s1_vld_q   <= 1'b0;
      s1_code_q  <= '0;
      s1_last_q  <= 1'b0;
      s2_vld_q   <= 1'b0;
      s2_therm_q <= '0;
      s2_code_q  <= '0;
      s2_sat_q   <= 1'b0;
      s2_last_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      max_q      <= max_d;
      hold_q     <= hold_d;
      hcnt_q     <= hcnt_d;
      done_q     <= done_d;
      s1_vld_q   <= s1_vld_d;
      s1_code_q  <= s1_code_d;
      s1_last_q  <= s1_last_d;
      s2_vld_q   <= s2_vld_d;
      s2_therm_q <= s2_therm_d;
      s2_code_q  <= s2_code_d;
      s2_sat_q   <= s2_sat_d;
      s2_last_q  <= s2_last_d;
    end
  end

endmodule

// File: tb/tb_thermo_encoder.sv
// Testbench for thermo_encoder: vector table, backpressure sequence,
// random traffic against a queue-based reference, sweep, reset-in-sweep
// and a loopback through a behavioural thermometer decoder.
module tb_thermo_encoder;
  localparam int WIDTH  = 40;
  localparam int CODE_W = 6;
  localparam int HOLD_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic [CODE_W-1:0] in_code;
  logic              in_valid;
  logic              in_ready;
  logic              sweep_start;
  logic [CODE_W-1:0] sweep_max;
  logic [HOLD_W-1:0] sweep_hold;
  logic [WIDTH-1:0]  out_therm;
  logic [CODE_W-1:0] out_code;
  logic              out_sat;
  logic              out_valid;
  logic              out_ready;
  logic              sweep_busy;
  logic              sweep_done;

  always #5 clk = ~clk;

  thermo_encoder #(.WIDTH(WIDTH), .CODE_W(CODE_W), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst),
    .in_code(in_code), .in_valid(in_valid), .in_ready(in_ready),
    .sweep_start(sweep_start), .sweep_max(sweep_max), .sweep_hold(sweep_hold),
    .out_therm(out_therm), .out_code(out_code), .out_sat(out_sat),
    .out_valid(out_valid), .out_ready(out_ready),
    .sweep_busy(sweep_busy), .sweep_done(sweep_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: n ones from the bottom, capped at the word width.
  function automatic logic [WIDTH-1:0] model_therm(input int n);
    logic [63:0] m;
    if (n >= WIDTH) return '1;
    m = (64'd1 << n) - 64'd1;
    return m[WIDTH-1:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: accepted codes queue up, outputs must match in order.
  logic              mon_en = 1'b0;
  int                sbq[$];
  logic              stall_prev = 1'b0;
  logic [WIDTH-1:0]  st_therm;
  logic [CODE_W-1:0] st_code;
  logic              st_sat;

  always @(negedge clk) begin
    int n;
    if (mon_en && !rst) begin
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'(1));
        chk("stall_therm", 64'(out_therm), 64'(st_therm));
        chk("stall_code", 64'(out_code), 64'(st_code));
        chk("stall_sat", 64'(out_sat), 64'(st_sat));
      end
      if (in_valid && in_ready) sbq.push_back(int'(in_code));
      if (out_valid && out_ready) begin
        chk("sb_pending", 64'(sbq.size() != 0), 64'(1));
        if (sbq.size() != 0) begin
          n = sbq.pop_front();
          chk("sb_code", 64'(out_code), 64'(n));
          chk("sb_therm", 64'(out_therm), 64'(model_therm(n)));
          chk("sb_sat", 64'(out_sat), 64'(n > WIDTH));
        end
      end
      stall_prev = out_valid && !out_ready;
      st_therm   = out_therm;
      st_code    = out_code;
      st_sat     = out_sat;
    end else begin
      stall_prev = 1'b0;
    end
  end

  typedef struct {
    int               code;
    logic [WIDTH-1:0] therm;
    logic             sat;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    logic acc;
    int   outs[$];
    int   ocyc[$];
    int   done_cnt;
    int   done_cyc;
    logic found;
    int   bad;
    int   prev_dec;
    int   exp_next;
    int   dec;

    tbl[0] = '{0,  40'h0000000000, 1'b0};
    tbl[1] = '{1,  40'h0000000001, 1'b0};
    tbl[2] = '{31, 40'h007FFFFFFF, 1'b0};
    tbl[3] = '{32, 40'h00FFFFFFFF, 1'b0};
    tbl[4] = '{39, 40'h7FFFFFFFFF, 1'b0};
    tbl[5] = '{40, 40'hFFFFFFFFFF, 1'b0};
    tbl[6] = '{45, 40'hFFFFFFFFFF, 1'b1};
    tbl[7] = '{63, 40'hFFFFFFFFFF, 1'b1};

    rst = 1'b1; in_code = '0; in_valid = 1'b0; sweep_start = 1'b0;
    sweep_max = '0; sweep_hold = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'(0));
    chk("rst_therm", 64'(out_therm), 64'(0));
    chk("rst_code", 64'(out_code), 64'(0));
    chk("rst_sat", 64'(out_sat), 64'(0));
    chk("rst_busy", 64'(sweep_busy), 64'(0));
    chk("rst_done", 64'(sweep_done), 64'(0));
    rst = 1'b0;
    tick();

    // Single codes: 2-cycle latency, exact words.
    mon_en = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_code = CODE_W'(tbl[i].code);
      in_valid = 1'b1;
      #1;
      chk("tbl_in_ready", 64'(in_ready), 64'(1));
      tick();
      in_valid = 1'b0;
      chk("tbl_lat1_valid", 64'(out_valid), 64'(0));
      tick();
      chk("tbl_valid", 64'(out_valid), 64'(1));
      chk("tbl_therm", 64'(out_therm), 64'(tbl[i].therm));
      chk("tbl_sat", 64'(out_sat), 64'(tbl[i].sat));
      chk("tbl_code", 64'(out_code), 64'(tbl[i].code));
      tick();
    end

    // Back-to-back 5,6,7 with the output stalled while 5 is presented.
    in_code = 6'd5; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_code = 6'd6; out_ready = 1'b0;
    tick();
    in_code = 6'd7;
    #1;
    chk("bb_in_ready_full", 64'(in_ready), 64'(0));
    chk("bb_therm_1", 64'(out_therm), 64'h1F);
    tick();
    chk("bb_in_ready_full2", 64'(in_ready), 64'(0));
    chk("bb_therm_2", 64'(out_therm), 64'h1F);
    chk("bb_valid_2", 64'(out_valid), 64'(1));
    tick();
    out_ready = 1'b1;
    #1;
    chk("bb_in_ready_resume", 64'(in_ready), 64'(1));
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    chk("bb_drained", 64'(sbq.size()), 64'(0));

    // Random traffic with random backpressure.
    acc = 1'b0;
    for (int c = 0; c < 2000; c++) begin
      @(posedge clk);
      #1;
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_code  = CODE_W'($urandom_range(0, 63));
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
    end
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) tick();
    chk("rand_drained", 64'(sbq.size()), 64'(0));
    mon_en = 1'b0;

    // Sweep 0..3, hold 2, with a coincident in_valid that must lose.
    sweep_max = 6'd3; sweep_hold = 8'd2; sweep_start = 1'b1;
    in_valid = 1'b1; in_code = 6'd9;
    #1;
    chk("sw_start_in_ready", 64'(in_ready), 64'(0));
    tick();
    sweep_start = 1'b0; in_valid = 1'b0;
    chk("sw_busy", 64'(sweep_busy), 64'(1));
    done_cnt = 0; done_cyc = -1;
    bad = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        outs.push_back(int'(out_code));
        ocyc.push_back(c);
        chk("sw_therm", 64'(out_therm), 64'(model_therm(int'(out_code))));
      end
      if (sweep_done) begin
        done_cnt++;
        done_cyc = c;
      end
      if (sweep_busy && in_ready) bad++;
    end
    chk("sw_in_ready_low", 64'(bad), 64'(0));
    chk("sw_count", 64'(outs.size()), 64'(4));
    for (int i = 0; i < outs.size() && i < 4; i++) begin
      chk("sw_code", 64'(outs[i]), 64'(i));
      if (i > 0) chk("sw_spacing", 64'(ocyc[i] - ocyc[i-1]), 64'(2));
    end
    chk("sw_done_cnt", 64'(done_cnt), 64'(1));
    if (ocyc.size() > 0) chk("sw_done_time", 64'(done_cyc), 64'(ocyc[ocyc.size()-1] + 1));
    chk("sw_busy_end", 64'(sweep_busy), 64'(0));

    // Same sweep, reset while code 2 is being issued.
    tick();
    sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 20; c++) begin
      if (!found) begin
        @(negedge clk);
        if (out_valid && out_code == 6'd1) begin
          found = 1'b1;
          rst = 1'b1;
        end
      end
    end
    chk("rs_found", 64'(found), 64'(1));
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rs_valid", 64'(out_valid), 64'(0));
    chk("rs_therm", 64'(out_therm), 64'(0));
    chk("rs_code", 64'(out_code), 64'(0));
    chk("rs_busy", 64'(sweep_busy), 64'(0));
    chk("rs_done", 64'(sweep_done), 64'(0));
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid || sweep_done || sweep_busy) bad++;
    end
    chk("rs_quiet", 64'(bad), 64'(0));
    chk("rs_in_ready", 64'(in_ready), 64'(1));

    // Loopback: sweep 0..40 (hold 0) through a popcount decoder.
    tick();
    sweep_max = 6'd40; sweep_hold = 8'd0; sweep_start = 1'b1;
    tick();
    sweep_start = 1'b0;
    prev_dec = -1; exp_next = 0; done_cnt = 0;
    for (int c = 0; c < 600; c++) begin
      if (done_cnt == 0) begin
        @(posedge clk);
        #1;
        out_ready = ($urandom_range(0, 2) != 0);
        @(negedge clk);
        if (out_valid && out_ready) begin
          dec = $countones(out_therm);
          chk("lb_shape", 64'(out_therm), 64'(model_therm(dec)));
          chk("lb_decode", 64'(dec), 64'((int'(out_code) < WIDTH) ? int'(out_code) : WIDTH));
          chk("lb_order", 64'(out_code), 64'(exp_next));
          chk("lb_mono", 64'(dec > prev_dec), 64'(1));
          chk("lb_sat", 64'(out_sat), 64'(0));
          prev_dec = dec;
          exp_next++;
        end
        if (sweep_done) done_cnt++;
      end
    end
    chk("lb_words", 64'(exp_next), 64'(41));
    chk("lb_done", 64'(done_cnt), 64'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
